// File: rtl/fano_pkg.sv
// Shared constants and types for the convolutional encoder and the Fano decoder path.
package fano_pkg;

    localparam int unsigned K_DEF  = 7;
    localparam logic [6:0]  G0_DEF = 7'o171;
    localparam logic [6:0]  G1_DEF = 7'o133;

    // Puncture masks, two bits per symbol, symbol 0 in the low bits
    localparam logic [1:0] PUNCT_R12 = 2'b11;
    localparam logic [3:0] PUNCT_R23 = 4'b0111;

    typedef enum logic {
        S_DATA = 1'b0,
        S_TAIL = 1'b1
    } enc_state_e;

    typedef struct packed {
        logic       last;
        logic [1:0] mask;
        logic [1:0] sym;
    } sym_beat_t;

endpackage

// File: rtl/conv_branch_gen.sv
// Combinational branch generator: K-bit encoder window to raw 2-bit symbol.
module conv_branch_gen
    import fano_pkg::*;
#(
    parameter int unsigned    K  = K_DEF,
    parameter logic [K-1:0]   G0 = K'(G0_DEF),
    parameter logic [K-1:0]   G1 = K'(G1_DEF)
) (
    input  logic [K-1:0] window,
    output logic [1:0]   raw_c
);

    always_comb begin
        raw_c[0] = ^(window & G0);
        raw_c[1] = ^(window & G1);
    end

endmodule

// File: rtl/conv_encoder_punct.sv
// Rate-1/2 convolutional encoder with puncturing and zero-tail frame termination.
module conv_encoder_punct
    import fano_pkg::*;
#(
    parameter int unsigned                  K            = K_DEF,
    parameter logic [K-1:0]                 G0           = K'(G0_DEF),
    parameter logic [K-1:0]                 G1           = K'(G1_DEF),
    parameter int unsigned                  PUNCT_PERIOD = 1,
    parameter logic [2*PUNCT_PERIOD-1:0]    PUNCT_MASK   = (2*PUNCT_PERIOD)'(PUNCT_R12),
    parameter bit                           DEBUG        = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_vld,
    input  logic       i_bit,
    input  logic       i_last,
    output logic       o_in_rdy,
    output logic       o_vld,
    input  logic       i_out_rdy,
    output logic [1:0] o_sym,
    output logic [1:0] o_mask,
    output logic       o_last
);

    localparam int unsigned SW = K - 1;
    localparam int unsigned TW = $clog2(K - 1);
    localparam int unsigned PW = (PUNCT_PERIOD > 1) ? $clog2(PUNCT_PERIOD) : 1;
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);
    localparam logic [PW-1:0] P_LAST    = PW'(PUNCT_PERIOD - 1);

    enc_state_e    state;
    logic [SW-1:0] s;
    logic [PW-1:0] p;
    logic [TW-1:0] tail_cnt;
    sym_beat_t     out_q;

    logic          slot_free_c;
    logic          accept_c;
    logic          gen_c;
    logic          bit_c;
    logic [K-1:0]  window_c;
    logic [1:0]    raw_c;
    logic [1:0]    m_c;
    logic [PW-1:0] p_inc_c;

    // Handshake, window assembly and puncture mask lookup
    always_comb begin
        slot_free_c = !o_vld || i_out_rdy;
        o_in_rdy    = (state == S_DATA) && slot_free_c;
        accept_c    = i_vld && o_in_rdy;
        gen_c       = accept_c || ((state == S_TAIL) && slot_free_c);
        bit_c       = (state == S_DATA) && i_bit;
        window_c    = {bit_c, s};
        m_c         = PUNCT_MASK[2*p +: 2];
        p_inc_c     = (p == P_LAST) ? '0 : p + 1'b1;
    end

    conv_branch_gen #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_branch (
        .window (window_c),
        .raw_c  (raw_c)
    );

    // Tail symbols shift zeros in; the final one clears p so each frame starts at index 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_DATA;
            s        <= '0;
            p        <= '0;
            tail_cnt <= '0;
            o_vld    <= 1'b0;
            out_q    <= '0;
        end else if (gen_c) begin
            o_vld      <= 1'b1;
            out_q.sym  <= raw_c & m_c;
            out_q.mask <= m_c;
            s          <= window_c[K-1:1];
            if ((state == S_TAIL) && (tail_cnt == TAIL_LAST)) begin
                out_q.last <= 1'b1;
                state      <= S_DATA;
                p          <= '0;
                tail_cnt   <= '0;
            end else begin
                out_q.last <= 1'b0;
                p          <= p_inc_c;
                if (state == S_TAIL) begin
                    tail_cnt <= tail_cnt + 1'b1;
                end else if (i_last) begin
                    state    <= S_TAIL;
                    tail_cnt <= '0;
                end
            end
        end else if (i_out_rdy) begin
            o_vld      <= 1'b0;
            out_q.last <= 1'b0;
        end
    end

    assign o_sym  = out_q.sym;
    assign o_mask = out_q.mask;
    assign o_last = out_q.last;

    if (DEBUG) begin : g_dbg
        (* mark_debug = "true" *) logic [5:0] dbg_probe;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dbg_probe <= '0;
            end else begin
                dbg_probe <= {state == S_TAIL, i_vld, o_in_rdy, o_vld, i_out_rdy, out_q.last};
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: rate 1/2 and rate 2/3 instances on shared inputs.
module tb_conv_encoder_punct;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_vld = 1'b0, i_bit = 1'b0, i_last = 1'b0, i_out_rdy = 1'b0;
    logic       o_in_rdy_a, o_vld_a, o_last_a, o_in_rdy_b, o_vld_b, o_last_b;
    logic [1:0] o_sym_a, o_mask_a, o_sym_b, o_mask_b;

    int checks = 0;
    int errors = 0;

    bit         fb [1024];
    bit         fl [1024];
    int         acc_edge [1024];
    logic [4:0] qa [$];
    logic [4:0] qb [$];
    logic [4:0] exp_a [$];
    int         gen_edge [$];
    int         edge_cnt = 0;
    int         stall_changes, tail_rdy_hi;
    bit         timed_out;
    logic [1:0] imp_sym [7];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    conv_encoder_punct u_a (
        .clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_bit(i_bit), .i_last(i_last),
        .o_in_rdy(o_in_rdy_a), .o_vld(o_vld_a), .i_out_rdy(i_out_rdy),
        .o_sym(o_sym_a), .o_mask(o_mask_a), .o_last(o_last_a)
    );

    conv_encoder_punct #(.PUNCT_PERIOD(2), .PUNCT_MASK(4'b0111)) u_b (
        .clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_bit(i_bit), .i_last(i_last),
        .o_in_rdy(o_in_rdy_b), .o_vld(o_vld_b), .i_out_rdy(i_out_rdy),
        .o_sym(o_sym_b), .o_mask(o_mask_b), .o_last(o_last_b)
    );

    task automatic clear_frame();
        for (int i = 0; i < 1024; i++) begin
            fb[i] = 1'b0;
            fl[i] = 1'b0;
        end
    endtask

    // Reference encoder for the unpunctured instance, K=7, 171/133 octal
    function automatic void build_exp(input int n);
        logic [5:0] st;
        logic [6:0] w;
        exp_a.delete();
        st = '0;
        for (int i = 0; i < n; i++) begin
            w  = {fb[i], st};
            exp_a.push_back({1'b0, 2'b11, ^(w & 7'o133), ^(w & 7'o171)});
            st = w[6:1];
            if (fl[i]) begin
                for (int t = 0; t < 6; t++) begin
                    w  = {1'b0, st};
                    exp_a.push_back({(t == 5), 2'b11, ^(w & 7'o133), ^(w & 7'o171)});
                    st = w[6:1];
                end
            end
        end
    endfunction

    // Drives fb/fl as frames and records consumed symbols, acceptance and generation edges
    task automatic run_frame(input int n, input int nframes, input bit rnd);
        int idx, lasts, cyc, budget;
        bit in_tail, free, stalled;
        logic [5:0] held;
        idx = 0; lasts = 0; cyc = 0; in_tail = 1'b0; budget = n * 4 + 100;
        qa.delete(); qb.delete(); gen_edge.delete();
        stall_changes = 0; tail_rdy_hi = 0;
        while (lasts < nframes && cyc < budget) begin
            i_vld     = (idx < n);
            i_bit     = (idx < n) ? fb[idx] : 1'b0;
            i_last    = (idx < n) ? fl[idx] : 1'b0;
            i_out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_tail && !(o_vld_a && o_last_a) && o_in_rdy_a) tail_rdy_hi++;
            free    = !o_vld_a || i_out_rdy;
            stalled = o_vld_a && !i_out_rdy;
            held    = {o_vld_a, o_last_a, o_mask_a, o_sym_a};
            if (o_vld_a && i_out_rdy) begin
                qa.push_back({o_last_a, o_mask_a, o_sym_a});
                qb.push_back({o_last_b, o_mask_b, o_sym_b});
                if (o_last_a) lasts++;
            end
            if (i_vld && o_in_rdy_a) begin
                acc_edge[idx] = edge_cnt + 1;
                if (fl[idx]) in_tail = 1'b1;
                idx++;
            end
            @(posedge clk); #1;
            if (o_vld_a && o_last_a) in_tail = 1'b0;
            if (stalled && held !== {o_vld_a, o_last_a, o_mask_a, o_sym_a}) stall_changes++;
            if (o_vld_a && free) gen_edge.push_back(edge_cnt);
            cyc++;
        end
        timed_out = (lasts < nframes);
        i_vld = 1'b0; i_bit = 1'b0; i_last = 1'b0; i_out_rdy = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_vld_a !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", o_vld_a); end
        checks++; if (o_sym_a !== 2'b00) begin errors++; $display("FAIL reset_sym: got %b expected 00", o_sym_a); end
        checks++; if (o_mask_a !== 2'b00) begin errors++; $display("FAIL reset_mask: got %b expected 00", o_mask_a); end
        checks++; if (o_last_a !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", o_last_a); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_in_rdy_a !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b expected 1", o_in_rdy_a); end
        checks++; if (o_vld_b !== 1'b0) begin errors++; $display("FAIL reset_vld_b: got %b expected 0", o_vld_b); end
    endtask

    task automatic test_impulse();
        logic [4:0] e;
        clear_frame();
        fb[0] = 1'b1; fl[0] = 1'b1;
        run_frame(1, 1, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL impulse_timeout: got %0d symbols expected 7", qa.size()); end
        checks++; if (qa.size() != 7) begin errors++; $display("FAIL impulse_count: got %0d expected 7", qa.size()); end
        for (int i = 0; i < qa.size() && i < 7; i++) begin
            e = {(i == 6), 2'b11, imp_sym[i]};
            checks++;
            if (qa[i] !== e) begin errors++; $display("FAIL impulse_sym[%0d]: got %b expected %b", i, qa[i], e); end
        end
    endtask

    task automatic test_punct();
        logic [4:0] e;
        clear_frame();
        fb[0] = 1'b1; fb[1] = 1'b1; fl[1] = 1'b1;
        build_exp(2);
        run_frame(2, 1, 1'b0);
        checks++; if (qb.size() != 8) begin errors++; $display("FAIL punct_count: got %0d expected 8", qb.size()); end
        if (qb.size() == 8) begin
            checks++; if (qb[0] !== 5'b0_11_11) begin errors++; $display("FAIL punct_sym0: got %b expected 01111", qb[0]); end
            checks++; if (qb[1] !== 5'b0_01_00) begin errors++; $display("FAIL punct_sym1: got %b expected 00100", qb[1]); end
            for (int i = 2; i < 8; i++) begin
                e = {(i == 7), ((i % 2) == 0) ? 2'b11 : 2'b01, 2'b00};
                checks++;
                if ({qb[i][4], qb[i][3:2]} !== {e[4], e[3:2]}) begin
                    errors++; $display("FAIL punct_tail_mask[%0d]: got last/mask %b expected %b", i, qb[i][4:2], e[4:2]);
                end
            end
        end
        for (int i = 0; i < qa.size() && i < exp_a.size(); i++) begin
            checks++;
            if (qa[i] !== exp_a[i]) begin errors++; $display("FAIL punct_r12[%0d]: got %b expected %b", i, qa[i], exp_a[i]); end
        end
    endtask

    task automatic test_backpressure();
        clear_frame();
        for (int i = 0; i < 20; i++) fb[i] = 1'($urandom_range(0, 1));
        fl[19] = 1'b1;
        build_exp(20);
        run_frame(20, 1, 1'b1);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got %0d symbols expected 26", qa.size()); end
        checks++; if (qa.size() != 26) begin errors++; $display("FAIL bp_count: got %0d expected 26", qa.size()); end
        for (int i = 0; i < qa.size() && i < exp_a.size(); i++) begin
            checks++;
            if (qa[i] !== exp_a[i]) begin errors++; $display("FAIL bp_sym[%0d]: got %b expected %b", i, qa[i], exp_a[i]); end
        end
        checks++; if (stall_changes != 0) begin errors++; $display("FAIL bp_hold: got %0d changes while stalled expected 0", stall_changes); end
        checks++; if (tail_rdy_hi != 0) begin errors++; $display("FAIL bp_tail_rdy: got %0d cycles with o_in_rdy=1 expected 0", tail_rdy_hi); end
    endtask

    task automatic test_back_to_back();
        bit pat [10] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0};
        clear_frame();
        for (int i = 0; i < 10; i++) fb[i] = pat[i];
        fl[4] = 1'b1; fl[9] = 1'b1;
        build_exp(10);
        run_frame(10, 2, 1'b0);
        checks++; if (qa.size() != 22) begin errors++; $display("FAIL b2b_count: got %0d expected 22", qa.size()); end
        for (int i = 0; i < qa.size() && i < exp_a.size(); i++) begin
            checks++;
            if (qa[i] !== exp_a[i]) begin errors++; $display("FAIL b2b_sym[%0d]: got %b expected %b", i, qa[i], exp_a[i]); end
        end
        checks++;
        if (gen_edge.size() != 22) begin
            errors++; $display("FAIL b2b_gen: got %0d generated expected 22", gen_edge.size());
        end else begin
            checks++; if (acc_edge[5] != gen_edge[10] + 1) begin errors++; $display("FAIL b2b_next_accept: got edge %0d expected %0d", acc_edge[5], gen_edge[10] + 1); end
            checks++; if (gen_edge[21] - gen_edge[0] != 21) begin errors++; $display("FAIL b2b_gaps: got span %0d expected 21", gen_edge[21] - gen_edge[0]); end
        end
        checks++;
        if (qb.size() < 12 || qb[11][3:2] !== 2'b11) begin
            errors++; $display("FAIL b2b_punct_restart: got %0d symbols, frame2 mask %b expected 11", qb.size(), (qb.size() >= 12) ? qb[11][3:2] : 2'bxx);
        end
    endtask

    task automatic test_reset_mid_tail();
        int seen;
        logic [4:0] e;
        i_vld = 1'b1; i_bit = 1'b1; i_last = 1'b1; i_out_rdy = 1'b1;
        @(posedge clk); #1;
        i_vld = 1'b0; i_bit = 1'b0; i_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if ({o_vld_a, o_last_a, o_mask_a, o_sym_a} !== 6'b0) begin
            errors++; $display("FAIL midtail_outputs: got %b expected 000000", {o_vld_a, o_last_a, o_mask_a, o_sym_a}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        checks++; if (o_in_rdy_a !== 1'b1) begin errors++; $display("FAIL midtail_in_rdy: got %b expected 1", o_in_rdy_a); end
        @(posedge clk); #1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_vld_a) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midtail_leftover: got %0d valid cycles expected 0", seen); end
        clear_frame();
        fb[0] = 1'b1; fl[0] = 1'b1;
        run_frame(1, 1, 1'b0);
        checks++; if (qa.size() != 7) begin errors++; $display("FAIL midtail_count: got %0d expected 7", qa.size()); end
        for (int i = 0; i < qa.size() && i < 7; i++) begin
            e = {(i == 6), 2'b11, imp_sym[i]};
            checks++;
            if (qa[i] !== e) begin errors++; $display("FAIL midtail_sym[%0d]: got %b expected %b", i, qa[i], e); end
        end
    endtask

    task automatic test_throughput();
        int bad, nlast;
        clear_frame();
        for (int i = 0; i < 1000; i++) fb[i] = ((i % 3) == 0) ^ ((i % 7) == 1);
        fl[999] = 1'b1;
        build_exp(1000);
        run_frame(1000, 1, 1'b0);
        bad = 0; nlast = 0;
        for (int i = 0; i < qa.size() && i < exp_a.size(); i++) begin
            if (qa[i] !== exp_a[i]) bad++;
            if (qa[i][4]) nlast++;
        end
        checks++; if (qa.size() != 1006) begin errors++; $display("FAIL tput_count: got %0d expected 1006", qa.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL tput_data: got %0d wrong symbols expected 0", bad); end
        checks++; if (nlast != 1) begin errors++; $display("FAIL tput_last: got %0d expected 1", nlast); end
        checks++;
        if (gen_edge.size() != 1006) begin
            errors++; $display("FAIL tput_gen: got %0d generated expected 1006", gen_edge.size());
        end else begin
            checks++; if (gen_edge[0] != acc_edge[0]) begin errors++; $display("FAIL tput_latency: got edge %0d expected %0d", gen_edge[0], acc_edge[0]); end
            checks++; if (gen_edge[1005] != acc_edge[0] + 1005) begin errors++; $display("FAIL tput_span: got edge %0d expected %0d", gen_edge[1005], acc_edge[0] + 1005); end
        end
    endtask

    initial begin
        imp_sym = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
        test_reset();
        test_impulse();
        test_punct();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_tail();
        test_throughput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
